// File: rtl/game_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// game_ctrl_fsm
//
// Top-level controller for the VGA snake game. It runs the menu / play /
// pause / game-over state machine, handles difficulty selection in the menu,
// generates the difficulty-scaled snake move tick, and emits a one-cycle
// game reset pulse whenever a fresh game begins.
//
// Parameters
//   LEVELS        number of difficulty levels (difficulty is 1..LEVELS)
//   LEVEL_W       width of the difficulty output
//   DEFAULT_LEVEL difficulty after reset
//   TICK_BASE     move-tick period in cycles at level 1
//   TICK_STEP     period reduction per level above 1
//   OVER_HOLD     cycles spent in OVER before auto-return (0 = never)
//
// Ports
//   pixel_clk   in   pixel clock, the only clock
//   sys_rst     in   synchronous active-high reset
//   key[5:0]    in   debounced key levels: [0] down, [1] up, [4] start/pause,
//                    [5] back; [3:2] unused
//   flag        in   collision / game-over request (level)
//   state[3:0]  out  one-hot state: 0001 MENU, 0010 PLAY, 0100 PAUSE, 1000 OVER
//   difficulty  out  current level, 1..LEVELS
//   move_tick   out  single-cycle pulse that advances the snake one step
//   game_rst    out  single-cycle pulse on each new game start
// -----------------------------------------------------------------------------
module game_ctrl_fsm #(
  parameter int LEVELS        = 3,
  parameter int LEVEL_W       = 2,
  parameter int DEFAULT_LEVEL = 1,
  parameter int TICK_BASE     = 2_500_000,
  parameter int TICK_STEP     = 500_000,
  parameter int OVER_HOLD     = 250_000_000
) (
  input  logic               pixel_clk,
  input  logic               sys_rst,
  input  logic [5:0]         key,
  input  logic               flag,
  output logic [3:0]         state,
  output logic [LEVEL_W-1:0] difficulty,
  output logic               move_tick,
  output logic               game_rst
);

  localparam int CNT_W  = $clog2(TICK_BASE + 1);
  localparam int HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;

  localparam logic [CNT_W-1:0]   BASE_C    = CNT_W'(TICK_BASE);
  localparam logic [CNT_W-1:0]   STEP_C    = CNT_W'(TICK_STEP);
  localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'((OVER_HOLD > 0) ? OVER_HOLD - 1 : 0);
  localparam logic [HOLD_W-1:0]  ONE_H     = HOLD_W'(1);
  localparam logic [LEVEL_W-1:0] LVL_MIN   = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVELS);
  localparam logic [LEVEL_W-1:0] LVL_RST   = LEVEL_W'(DEFAULT_LEVEL);

  typedef enum logic [3:0] {
    S_MENU  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_PAUSE = 4'b0100,
    S_OVER  = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         key_q;
  logic [5:0]         key_edge;
  logic               ed_down, ed_up, ed_start, ed_back;
  logic               unused_key_edge;
  logic [LEVEL_W-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]   lvl_off;
  logic [CNT_W-1:0]   period_last;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               tick_q, tick_d;
  logic               grst_q, grst_d;

  // Rising-edge detection: the key is acted on in the cycle it is first seen
  // high, so state reacts at the same edge that samples the key.
  assign key_edge        = key & ~key_q;
  assign ed_down         = key_edge[0];
  assign ed_up           = key_edge[1];
  assign ed_start        = key_edge[4];
  assign ed_back         = key_edge[5];
  assign unused_key_edge = ^key_edge[3:2];

  // Tick period P = TICK_BASE - (difficulty-1)*TICK_STEP; the counter wraps
  // at P-1.
  assign lvl_off     = CNT_W'(diff_q - LVL_MIN);
  assign period_last = BASE_C - lvl_off * STEP_C - ONE_C;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d    = state_q;
    diff_d     = diff_q;
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;

    case (state_q)
      S_MENU: begin
        if (ed_start) state_d = S_PLAY;
        // Simultaneous up and down cancel each other.
        if (ed_up && !ed_down) begin
          diff_d = (diff_q >= LVL_MAX) ? LVL_MIN : diff_q + LVL_MIN;
        end else if (ed_down && !ed_up) begin
          diff_d = (diff_q <= LVL_MIN) ? LVL_MAX : diff_q - LVL_MIN;
        end
      end
      S_PLAY: begin
        if (flag)          state_d = S_OVER;
        else if (ed_back)  state_d = S_MENU;
        else if (ed_start) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (ed_back)       state_d = S_MENU;
        else if (ed_start) state_d = S_PLAY;
      end
      S_OVER: begin
        if (ed_back)       state_d = S_MENU;
        else if (ed_start) state_d = S_PLAY;
        else if ((OVER_HOLD != 0) && (hold_q == HOLD_LAST)) state_d = S_MENU;
      end
      default: state_d = S_MENU;  // illegal one-hot encoding recovers to MENU
    endcase

    // A new game starts only from MENU or OVER; resuming from PAUSE does not
    // reset the snake.
    grst_d = (state_d == S_PLAY) && ((state_q == S_MENU) || (state_q == S_OVER));

    // The counter advances only when PLAY is both the current and the next
    // state, so leaving PLAY never emits a tick and the count frozen on entry
    // to PAUSE is exactly the one resumed from.
    if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
      if (tick_cnt_q >= period_last) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + ONE_C;
      end
    end else if ((state_d == S_PAUSE) ||
                 ((state_q == S_PAUSE) && (state_d == S_PLAY))) begin
      tick_cnt_d = tick_cnt_q;
    end else begin
      tick_cnt_d = '0;
    end

    // Hold counter is 0 on the first OVER cycle and outside OVER.
    hold_d = ((state_q == S_OVER) && (state_d == S_OVER)) ? hold_q + ONE_H : '0;
  end

  always_ff @(posedge pixel_clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (sys_rst) begin
      state_q    <= S_MENU;
      diff_q     <= LVL_RST;
      key_q      <= '1;  // a key held through reset produces no edge
      tick_cnt_q <= '0;
      hold_q     <= '0;
      tick_q     <= 1'b0;
      grst_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      diff_q     <= diff_d;
      key_q      <= key;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      tick_q     <= tick_d;
      grst_q     <= grst_d;
    end
  end

  assign state      = state_q;
  assign difficulty = diff_q;
  assign move_tick  = tick_q;
  assign game_rst   = grst_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl_fsm
//
// Directed bench for game_ctrl_fsm with LEVELS=3, TICK_BASE=8, TICK_STEP=2
// (periods 8/6/4 at levels 1/2/3). Two instances share all inputs: one with
// OVER_HOLD=16 and one with OVER_HOLD=0 (auto-return disabled). Inputs change
// 1 time unit after each rising edge and outputs are sampled there too, so
// every sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_game_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] key;
  logic       flag;

  logic [3:0] state,    state_nh;
  logic [1:0] diff,     diff_nh;
  logic       mtick,    mtick_nh;
  logic       grst,     grst_nh;

  int checks;
  int errors;

  game_ctrl_fsm #(
    .LEVELS(3), .LEVEL_W(2), .DEFAULT_LEVEL(1),
    .TICK_BASE(8), .TICK_STEP(2), .OVER_HOLD(16)
  ) dut (
    .pixel_clk (clk),
    .sys_rst   (rst),
    .key       (key),
    .flag      (flag),
    .state     (state),
    .difficulty(diff),
    .move_tick (mtick),
    .game_rst  (grst)
  );

  game_ctrl_fsm #(
    .LEVELS(3), .LEVEL_W(2), .DEFAULT_LEVEL(1),
    .TICK_BASE(8), .TICK_STEP(2), .OVER_HOLD(0)
  ) dut_nh (
    .pixel_clk (clk),
    .sys_rst   (rst),
    .key       (key),
    .flag      (flag),
    .state     (state_nh),
    .difficulty(diff_nh),
    .move_tick (mtick_nh),
    .game_rst  (grst_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the masked keys for one edge, then drop them. Outputs seen on
  // return reflect that edge; callers insert a tick() before the next press.
  task automatic pulse(input logic [5:0] m);
    key = key | m;
    tick();
    key = key & ~m;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    key    = 6'h10;   // start held through reset
    flag   = 1'b0;

    // ---------------- reset, start key held through it ----------------
    tick();
    tick();
    check("rst_state",    32'(state), 32'h1);
    check("rst_diff",     32'(diff),  32'h1);
    check("rst_tick",     32'(mtick), 32'h0);
    check("rst_grst",     32'(grst),  32'h0);
    check("rst_state_nh", 32'(state_nh), 32'h1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_start_grst", 32'(grst), 32'h0);
    end
    check("held_start_state", 32'(state), 32'h1);
    key = 6'h00;
    tick();
    pulse(6'h10);
    check("start_state", 32'(state), 32'h2);
    check("start_grst",  32'(grst),  32'h1);
    tick();
    check("grst_one_cycle", 32'(grst),  32'h0);
    check("play_state",     32'(state), 32'h2);
    pulse(6'h20);
    check("play_back_menu", 32'(state), 32'h1);
    tick();

    // ---------------- difficulty selection in MENU ----------------
    pulse(6'h02); check("up_1_to_2",     32'(diff), 32'h2); tick();
    pulse(6'h02); check("up_2_to_3",     32'(diff), 32'h3); tick();
    pulse(6'h02); check("up_wrap_3_1",   32'(diff), 32'h1); tick();
    pulse(6'h01); check("down_wrap_1_3", 32'(diff), 32'h3); tick();
    pulse(6'h03); check("up_down_cancel", 32'(diff), 32'h3); tick();
    pulse(6'h20); check("menu_back_ignored", 32'(state), 32'h1); tick();

    // ---------------- level 3 game, P = 4 ----------------
    pulse(6'h10);  // cycle 0 = game_rst cycle
    check("p4_grst",   32'(grst),  32'h1);
    check("p4_c0_tick", 32'(mtick), 32'h0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) key[1] = 1'b1;   // up press during PLAY
      if (c == 3) key[1] = 1'b0;
      tick();
      check("p4_tick", 32'(mtick), 32'((c % 4) == 0));
    end
    check("play_diff_hold", 32'(diff), 32'h3);

    // Count is 2 in cycle 14: pause there.
    key[4] = 1'b1;
    tick();
    key[4] = 1'b0;
    check("pause_state", 32'(state), 32'h4);
    check("pause_entry_tick", 32'(mtick), 32'h0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("pause_no_tick", 32'(mtick), 32'h0);
    end
    check("pause_hold_state", 32'(state), 32'h4);

    key[4] = 1'b1;   // resume
    tick();
    key[4] = 1'b0;
    check("resume_state",   32'(state), 32'h2);
    check("resume_no_grst", 32'(grst),  32'h0);
    tick(); check("resume_r1_tick", 32'(mtick), 32'h0);
    tick(); check("resume_r2_tick", 32'(mtick), 32'h1);
    tick(); check("resume_r3_tick", 32'(mtick), 32'h0);
    tick();
    tick();          // count = 3: a tick would follow next cycle

    // ---------------- flag beats back, no tick on exit ----------------
    flag   = 1'b1;
    key[5] = 1'b1;
    tick();
    flag   = 1'b0;
    key[5] = 1'b0;
    check("flag_wins_state", 32'(state),    32'h8);
    check("flag_exit_tick",  32'(mtick),    32'h0);
    check("flag_nh_state",   32'(state_nh), 32'h8);
    tick();
    pulse(6'h10);
    check("over_restart_state", 32'(state), 32'h2);
    check("over_restart_grst",  32'(grst),  32'h1);
    check("over_restart_nh",    32'(state_nh), 32'h2);
    tick();

    // ---------------- auto-return after OVER_HOLD = 16 ----------------
    flag = 1'b1;
    tick();          // first OVER cycle
    flag = 1'b0;
    check("hold_entry", 32'(state), 32'h8);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("hold_stay", 32'(state), 32'h8);
    end
    tick();
    check("hold_return",   32'(state),    32'h1);
    check("nohold_at_16",  32'(state_nh), 32'h8);
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if ((i % 100) == 0) check("nohold_stay", 32'(state_nh), 32'h8);
    end
    pulse(6'h20);
    check("nohold_back", 32'(state_nh), 32'h1);
    tick();

    // ---------------- back wins over start in PAUSE ----------------
    pulse(6'h10); check("pp_play", 32'(state), 32'h2); tick();
    pulse(6'h10); check("pp_pause", 32'(state), 32'h4); tick();
    pulse(6'h30); check("pause_back_wins", 32'(state), 32'h1); tick();

    // ---------------- reset mid-game ----------------
    pulse(6'h10);
    tick();
    tick();
    rst = 1'b1;
    key = 6'h10;
    tick();
    check("midrst_state", 32'(state), 32'h1);
    check("midrst_diff",  32'(diff),  32'h1);
    check("midrst_tick",  32'(mtick), 32'h0);
    check("midrst_grst",  32'(grst),  32'h0);
    rst = 1'b0;
    tick();
    check("midrst_held_key", 32'(state), 32'h1);
    key = 6'h00;
    tick();

    // ---------------- level 1 game, P = 8 ----------------
    pulse(6'h10);
    check("p8_grst", 32'(grst), 32'h1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("p8_tick", 32'(mtick), 32'(c == 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
